// File: rtl/ttt_network_pkg.sv
// Shared types and constants for the ttt event router.
// Imported by the router top and its source-ID FIFO.
package ttt_network_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ITER = 1'b1
  } router_state_t;

  localparam logic [1:0] OP_INDPTR = 2'd0;
  localparam logic [1:0] OP_INDEX  = 2'd1;
  localparam logic [1:0] OP_WEIGHT = 2'd2;

  localparam int MIN_W = 1;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : MIN_W;
  endfunction

endpackage

// File: rtl/tt_um_jleugeri_ttt_fifo.sv
// Synchronous FIFO with async reset and full/empty flags.
// Pointers carry one extra wrap bit to tell full from empty.
module tt_um_jleugeri_ttt_fifo
  import ttt_network_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int DW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW:0]      wr_q;
  logic [DW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[DW] != rd_q[DW]) &&
                 (wr_q[DW-1:0] == rd_q[DW-1:0]);
  assign dout  = mem[rd_q[DW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[DW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (DW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (DW+1)'(1);
    end
  end

endmodule

// File: rtl/tt_um_jleugeri_ttt_router.sv
// Fan-out router: walks CSC connection lists per source ID
// and emits target/token events over a valid/ready port.
module tt_um_jleugeri_ttt_router
  import ttt_network_pkg::*;
#(
  parameter  int NUM_PROCESSORS  = 8,
  parameter  int NUM_CONNECTIONS = 64,
  parameter  int NUM_CHANNELS    = 2,
  parameter  int TOKEN_BITS      = 4,
  parameter  int QUEUE_DEPTH     = 4,
  parameter  int PROG_WIDTH      = 8,
  localparam int PW = $clog2(NUM_PROCESSORS),
  localparam int AW = $clog2(NUM_CONNECTIONS + 1),
  localparam int CW = chan_w(NUM_CHANNELS),
  localparam int EW = NUM_CHANNELS * TOKEN_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_en,
  input  logic [1:0]            prog_op,
  input  logic [AW-1:0]         prog_addr,
  input  logic [CW-1:0]         prog_channel,
  input  logic [PROG_WIDTH-1:0] prog_data,
  output logic                  prog_err,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [PW-1:0]         src_id,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [PW-1:0]         evt_target,
  output logic [EW-1:0]         evt_tokens,
  output logic                  done,
  output logic                  idle
);

  localparam int IW = $clog2(NUM_CONNECTIONS);

  logic [AW-1:0] indptr_mem [NUM_PROCESSORS+1];
  logic [PW-1:0] index_mem  [NUM_CONNECTIONS];
  logic [EW-1:0] weight_mem [NUM_CONNECTIONS];

  router_state_t state_q;
  router_state_t state_d;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] end_q;
  logic          pop;
  logic          load;
  logic          fifo_full;
  logic          fifo_empty;
  logic [PW-1:0] head_id;
  logic [PW:0]   head_ext;
  logic [PW:0]   head_nxt;
  logic [IW-1:0] conn;

  logic wr_ok;
  logic ptr_ok;
  logic conn_ok;
  logic chan_ok;

  assign src_ready = !fifo_full;
  assign idle = fifo_empty && (state_q == IDLE) && !evt_valid;

  assign head_ext = {1'b0, head_id};
  assign head_nxt = head_ext + (PW+1)'(1);
  assign conn     = addr_q[IW-1:0];

  tt_um_jleugeri_ttt_fifo #(
    .WIDTH (PW),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (src_valid && src_ready),
    .din   (src_id),
    .pop   (pop),
    .dout  (head_id),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Memories keep their contents across reset.
  assign wr_ok   = prog_en && idle;
  assign ptr_ok  = int'(prog_addr) <= NUM_PROCESSORS;
  assign conn_ok = int'(prog_addr) < NUM_CONNECTIONS;
  assign chan_ok = int'(prog_channel) < NUM_CHANNELS;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      unique case (1'b1)
        (prog_op == OP_INDPTR) && ptr_ok:
          indptr_mem[prog_addr[PW:0]] <=
            prog_data[AW-1:0];
        (prog_op == OP_INDEX) && conn_ok:
          index_mem[prog_addr[IW-1:0]] <=
            prog_data[PW-1:0];
        (prog_op == OP_WEIGHT) && conn_ok && chan_ok:
          weight_mem[prog_addr[IW-1:0]]
            [prog_channel*TOKEN_BITS +: TOKEN_BITS] <=
            prog_data[TOKEN_BITS-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!fifo_empty) state_d = ITER;
      ITER: if (addr_q >= end_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A malformed list (end below start) reads as zero fan-out.
  always_comb begin
    pop  = 1'b0;
    load = 1'b0;
    done = 1'b0;
    unique case (state_q)
      IDLE: pop = !fifo_empty;
      ITER: begin
        if (addr_q >= end_q) done = 1'b1;
        else load = !evt_valid || evt_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      end_q      <= '0;
      evt_valid  <= 1'b0;
      evt_target <= '0;
      evt_tokens <= '0;
      prog_err   <= 1'b0;
    end else begin
      if (pop) begin
        addr_q <= indptr_mem[head_ext];
        end_q  <= indptr_mem[head_nxt];
      end
      if (load) begin
        addr_q     <= addr_q + AW'(1);
        evt_target <= index_mem[conn];
        evt_tokens <= weight_mem[conn];
        evt_valid  <= 1'b1;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (prog_en && !idle) prog_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_router.sv
// Directed bench for the ttt router: per-cycle vector tables
// plus hand sequences for back-pressure, locking and reset.
module tb_tt_um_jleugeri_ttt_router;

  logic       clk = 1'b0;
  logic       reset;
  logic       prog_en;
  logic [1:0] prog_op;
  logic [6:0] prog_addr;
  logic [0:0] prog_channel;
  logic [7:0] prog_data;
  logic       prog_err;
  logic       src_valid;
  logic       src_ready;
  logic [2:0] src_id;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_target;
  logic [7:0] evt_tokens;
  logic       done;
  logic       idle;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tt_um_jleugeri_ttt_router dut (
    .clk          (clk),
    .reset        (reset),
    .prog_en      (prog_en),
    .prog_op      (prog_op),
    .prog_addr    (prog_addr),
    .prog_channel (prog_channel),
    .prog_data    (prog_data),
    .prog_err     (prog_err),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_id       (src_id),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_target   (evt_target),
    .evt_tokens   (evt_tokens),
    .done         (done),
    .idle         (idle)
  );

  typedef struct {
    logic       sv;
    logic [2:0] sid;
    logic       rdy;
    logic       v;
    logic [2:0] tgt;
    logic [7:0] tok;
    logic       dn;
    logic       idl;
  } vec_t;

  typedef struct {
    logic [2:0] tgt;
    logic [7:0] tok;
  } ev_t;

  vec_t tq[$];
  ev_t  exp_q[$];
  int   dones;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic prog(input logic [1:0] op,
                      input logic [6:0] a,
                      input logic [0:0] ch,
                      input logic [7:0] d);
    prog_op      = op;
    prog_addr    = a;
    prog_channel = ch;
    prog_data    = d;
    prog_en      = 1'b1;
    step();
    prog_en = 1'b0;
  endtask

  task automatic add(input logic sv,
                     input logic [2:0] sid,
                     input logic rdy,
                     input logic v,
                     input logic [2:0] tgt,
                     input logic [7:0] tok,
                     input logic dn,
                     input logic idl);
    vec_t r;
    r.sv = sv; r.sid = sid; r.rdy = rdy;
    r.v = v; r.tgt = tgt; r.tok = tok;
    r.dn = dn; r.idl = idl;
    tq.push_back(r);
  endtask

  task automatic run(input string tag);
    foreach (tq[i]) begin
      chk($sformatf("%s[%0d].valid", tag, i),
          evt_valid, tq[i].v);
      if (tq[i].v) begin
        chk($sformatf("%s[%0d].target", tag, i),
            evt_target, tq[i].tgt);
        chk($sformatf("%s[%0d].tokens", tag, i),
            evt_tokens, tq[i].tok);
      end
      chk($sformatf("%s[%0d].done", tag, i),
          done, tq[i].dn);
      chk($sformatf("%s[%0d].idle", tag, i),
          idle, tq[i].idl);
      src_valid = tq[i].sv;
      src_id    = tq[i].sid;
      evt_ready = tq[i].rdy;
      step();
    end
    src_valid = 1'b0;
    tq.delete();
  endtask

  task automatic expect_ev(input logic [2:0] t,
                           input logic [7:0] k);
    ev_t e;
    e.tgt = t;
    e.tok = k;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    dones = 0;
    evt_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (evt_valid) begin
        if (exp_q.size() == 0) begin
          chk({tag, ".extra"}, evt_valid, 0);
        end else begin
          ev_t e = exp_q.pop_front();
          chk($sformatf("%s.ev%0d.target", tag, n),
              evt_target, e.tgt);
          chk($sformatf("%s.ev%0d.tokens", tag, n),
              evt_tokens, e.tok);
          n++;
        end
      end
      if (done) dones++;
      if (idle && exp_q.size() == 0) break;
      step();
    end
    chk({tag, ".missing"}, exp_q.size(), 0);
    chk({tag, ".idle"}, idle, 1);
    exp_q.delete();
  endtask

  task automatic seq_src0(input string tag);
    add(1, 0, 1, 0, 0, 8'h00, 0, 1);
    add(0, 0, 1, 0, 0, 8'h00, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 0, 0);
    add(0, 0, 1, 1, 3, 8'hD2, 0, 0);
    add(0, 0, 1, 1, 5, 8'h01, 1, 0);
    add(0, 0, 1, 0, 0, 8'h00, 0, 1);
    run(tag);
  endtask

  initial begin
    reset        = 1'b1;
    prog_en      = 1'b0;
    prog_op      = 2'd0;
    prog_addr    = '0;
    prog_channel = '0;
    prog_data    = '0;
    src_valid    = 1'b0;
    src_id       = '0;
    evt_ready    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.idle", idle, 1);
    chk("rst.src_ready", src_ready, 1);
    chk("rst.evt_valid", evt_valid, 0);
    chk("rst.done", done, 0);
    chk("rst.prog_err", prog_err, 0);
    chk("rst.target", evt_target, 0);
    chk("rst.tokens", evt_tokens, 0);
    reset = 1'b0;
    step();

    // indptr = {0,2,2,5,5,5,5,5,5}
    prog(2'd0, 7'd0, 1'b0, 8'd0);
    prog(2'd0, 7'd1, 1'b0, 8'd2);
    prog(2'd0, 7'd2, 1'b0, 8'd2);
    for (int p = 3; p <= 8; p++)
      prog(2'd0, 7'(p), 1'b0, 8'd5);
    prog(2'd1, 7'd0, 1'b0, 8'd3);
    prog(2'd2, 7'd0, 1'b0, 8'h02);
    prog(2'd2, 7'd0, 1'b1, 8'hFD);
    prog(2'd1, 7'd1, 1'b0, 8'd5);
    prog(2'd2, 7'd1, 1'b0, 8'h01);
    prog(2'd2, 7'd1, 1'b1, 8'h00);
    prog(2'd1, 7'd2, 1'b0, 8'd1);
    prog(2'd2, 7'd2, 1'b0, 8'h07);
    prog(2'd2, 7'd2, 1'b1, 8'h08);
    prog(2'd1, 7'd3, 1'b0, 8'd6);
    prog(2'd2, 7'd3, 1'b0, 8'h0F);
    prog(2'd2, 7'd3, 1'b1, 8'h04);
    prog(2'd1, 7'd4, 1'b0, 8'd0);
    prog(2'd2, 7'd4, 1'b0, 8'h03);
    prog(2'd2, 7'd4, 1'b1, 8'h0E);
    prog(2'd0, 7'd9, 1'b0, 8'h3F);
    prog(2'd1, 7'd64, 1'b0, 8'h07);
    prog(2'd3, 7'd0, 1'b0, 8'hFF);
    chk("oob.prog_err", prog_err, 0);

    seq_src0("src0");

    add(1, 1, 1, 0, 0, 8'h00, 0, 1);
    add(0, 1, 1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 1, 0, 0, 8'h00, 1, 0);
    add(0, 1, 1, 0, 0, 8'h00, 0, 1);
    run("src1");

    add(1, 2, 1, 0, 0, 8'h00, 0, 1);
    add(0, 2, 1, 0, 0, 8'h00, 0, 0);
    add(0, 2, 1, 0, 0, 8'h00, 0, 0);
    add(0, 2, 1, 1, 1, 8'h87, 0, 0);
    add(0, 2, 0, 1, 6, 8'h4F, 0, 0);
    add(0, 2, 0, 1, 6, 8'h4F, 0, 0);
    add(0, 2, 1, 1, 6, 8'h4F, 0, 0);
    add(0, 2, 0, 1, 0, 8'hE3, 1, 0);
    add(0, 2, 0, 1, 0, 8'hE3, 0, 0);
    add(0, 2, 1, 1, 0, 8'hE3, 0, 0);
    add(0, 2, 1, 0, 0, 8'h00, 0, 1);
    run("src2");

    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fill%0d.src_ready", i),
          src_ready, 1);
      src_valid = 1'b1;
      src_id    = 3'd0;
      step();
    end
    src_valid = 1'b0;
    chk("full.src_ready", src_ready, 0);
    chk("full.evt_valid", evt_valid, 1);
    chk("full.target", evt_target, 3);
    evt_ready = 1'b1;
    step();
    chk("full.done", done, 1);
    chk("full.src_ready2", src_ready, 0);
    step();
    chk("full.src_ready3", src_ready, 0);
    chk("full.evt_valid3", evt_valid, 0);
    step();
    chk("recover.src_ready", src_ready, 1);
    for (int i = 0; i < 4; i++) begin
      expect_ev(3, 8'hD2);
      expect_ev(5, 8'h01);
    end
    drain("drain");
    chk("drain.dones", dones, 4);

    src_valid = 1'b1;
    src_id    = 3'd0;
    step();
    src_valid = 1'b0;
    chk("lock.busy", idle, 0);
    prog_op      = 2'd2;
    prog_addr    = 7'd0;
    prog_channel = 1'b0;
    prog_data    = 8'h05;
    prog_en      = 1'b1;
    step();
    prog_en = 1'b0;
    chk("lock.prog_err", prog_err, 1);
    expect_ev(3, 8'hD2);
    expect_ev(5, 8'h01);
    drain("lock");
    chk("lock.dones", dones, 1);
    src_valid = 1'b1;
    step();
    src_valid = 1'b0;
    expect_ev(3, 8'hD2);
    expect_ev(5, 8'h01);
    drain("rewalk");
    chk("rewalk.prog_err", prog_err, 1);

    evt_ready = 1'b1;
    src_valid = 1'b1;
    src_id    = 3'd0;
    step();
    src_id = 3'd1;
    step();
    src_valid = 1'b0;
    step();
    chk("mid.evt_valid0", evt_valid, 1);
    step();
    chk("mid.evt_valid", evt_valid, 1);
    chk("mid.done", done, 1);
    chk("mid.idle", idle, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst.evt_valid", evt_valid, 0);
    chk("arst.done", done, 0);
    chk("arst.prog_err", prog_err, 0);
    chk("arst.idle", idle, 1);
    chk("arst.target", evt_target, 0);
    chk("arst.tokens", evt_tokens, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post%0d.evt_valid", i),
          evt_valid, 0);
      chk($sformatf("post%0d.done", i), done, 0);
      chk($sformatf("post%0d.idle", i), idle, 1);
    end
    seq_src0("again");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_um_jleugeri_ttt_router.md
Name: tt_um_jleugeri_ttt_router

Overview:
Parametrised successor to the fan-out network stage. For each source processor ID it accepts, the block walks that processor's outgoing connections, stored in CSC form. Each connection yields an event: a target ID plus a signed token delta for each of NUM_CHANNELS token types. Source IDs are buffered in a FIFO, and events leave through a valid/ready handshake with back-pressure, feeding the processor array.

Parameters:
NUM_PROCESSORS, 8, number of processors (PW = $clog2(NUM_PROCESSORS))
NUM_CONNECTIONS, 64, connection memory depth (AW = $clog2(NUM_CONNECTIONS+1))
NUM_CHANNELS, 2, token types per connection (CW = max(1,$clog2(NUM_CHANNELS)))
TOKEN_BITS, 4, signed token delta width
QUEUE_DEPTH, 4, source-ID FIFO depth (power of two, >=2)
PROG_WIDTH, 8, programming data width (>= AW, >= TOKEN_BITS)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
prog_en  in  1  programming write strobe
prog_op  in  2  0 = indptr, 1 = target index, 2 = token weight, 3 = reserved (ignored)
prog_addr  in  AW  indptr slot (0..NUM_PROCESSORS) or connection address
prog_channel  in  CW  channel for op 2
prog_data  in  PROG_WIDTH  write data (low bits used)
prog_err  out  1  sticky: write attempted while not idle
src_valid  in  1  source ID offered
src_ready  out  1  FIFO not full
src_id  in  PW  firing processor
evt_valid  out  1  event present
evt_ready  in  1  consumer accepts
evt_target  out  PW  target processor
evt_tokens  out  NUM_CHANNELS*TOKEN_BITS  signed deltas; channel k in bits [k*TOKEN_BITS +: TOKEN_BITS]
done  out  1  one-cycle pulse when a source's walk completes
idle  out  1  FIFO empty, FSM in IDLE, evt_valid low

Behaviour:
- Reset (async assert, released on clock edge):
  - FSM goes to IDLE and the FIFO is emptied.
  - evt_valid=0, evt_target=0, evt_tokens=0, done=0, prog_err=0, src_ready=1, idle=1.
  - indptr, index and weight memories are not reset; their contents are retained across reset and undefined at power-up.
- Programming:
  - Writes take effect at the clock edge, and only when idle=1.
  - A prog_en while idle=0 is dropped and sets prog_err, which is cleared only by reset.
  - Out-of-range addresses or channels are dropped without setting prog_err.
- FIFO:
  - Push when src_valid && src_ready; src_ready = !full, with no same-cycle bypass.
  - Pop happens in IDLE. Sources are processed in FIFO order.
- FSM:
  - IDLE: if FIFO is non-empty, pop; addr <= indptr[id]; end <= indptr[id+1]; go to ITER.
  - ITER: if addr >= end, pulse done and go to IDLE. Else, if the output is free (!evt_valid || evt_ready), load the output with index/weights[addr], set evt_valid=1 and increment addr. Otherwise hold.
  - The comparison is >=, so a malformed indptr (end < start) is treated as zero fan-out.
  - Zero fan-out costs one ITER cycle plus done.
- Latency and throughput:
  - Source accepted at edge n: first evt_valid from edge n+2.
  - 1 event per cycle under evt_ready=1. Connections are emitted in ascending address order.
- Output handshake:
  - Outputs are stable while evt_valid && !evt_ready.
  - evt_valid drops on the edge where the last event is accepted, unless a new event is loaded on that same edge.
- Arithmetic and widths:
  - Weights are stored as TOKEN_BITS two's complement from prog_data[TOKEN_BITS-1:0]; no arithmetic is performed on them.
  - indptr and addr are AW bits wide, so no wrap is possible for values <= NUM_CONNECTIONS.
- Simultaneous events: push and pop in the same cycle leave the count unchanged. The done pulse may coincide with the acceptance of the final event.

Decomposition:
- Package ttt_network_pkg holds:
  - router_state_t enum {IDLE, ITER}.
  - prog_op constants OP_INDPTR, OP_INDEX, OP_WEIGHT.
  - Width helper localparams.
- Sub-module tt_um_jleugeri_ttt_fifo: parametrised sync FIFO (WIDTH, DEPTH) with async reset and full/empty flags.

Test Plan:
- Program indptr={0,2,2,5,...}; conns 0,1 -> targets 3,5 with weights (+2,-3),(+1,0); push src 0 with evt_ready=1 -> events (3,+2,-3) from edge n+2, then (5,+1,0), then done pulse.
- Push src 1 (indptr 2->2) -> no evt_valid, single done pulse, idle=1 two cycles later.
- Push src 2 (3 conns) with evt_ready toggling 1,0,0,1,... -> outputs held stable while stalled, exactly 3 events in order, none lost or duplicated.
- With evt_ready=0, push 5 sources at QUEUE_DEPTH=4 -> src_ready falls after the FIFO fills; src_ready recovers when evt_ready=1.
- prog_en asserted during a walk -> memory unchanged (re-walk yields the original weights), prog_err=1 until reset.
- Assert reset mid-walk (async, between edges) -> evt_valid, done, prog_err 0 immediately, FIFO empty; after release, re-pushing src 0 gives identical events.
